// File: rtl/spi_arb.sv
// spi_arb: round-robin arbiter sharing one SPI engine among NREQ requesters.
// Optional BUSY watchdog enabled by defining SPI_ARB_TIMEOUT_EN.
module spi_arb #(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ-1:0]   req_wr,
  input  logic [8*NREQ-1:0] req_addr,
  input  logic [8*NREQ-1:0] req_din,
  output logic [NREQ-1:0]   gnt,
  output logic [NREQ-1:0]   rsp_valid,
  output logic              rsp_err,
  output logic [7:0]        rsp_dout,
  output logic              timeout_flag,
  output logic              eng_rst,
  output logic              eng_wr,
  output logic [7:0]        eng_addr,
  output logic [7:0]        eng_din,
  input  logic              eng_done,
  input  logic              eng_err,
  input  logic [7:0]        eng_dout
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {
    IDLE,
    CMD,
    BUSY,
    RESP
  } state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   win_q, win_d;
  logic [IW-1:0]   last_q, last_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [NREQ-1:0] vld_q, vld_d;
  logic            err_q, err_d;
  logic [7:0]      dout_q, dout_d;
  logic            erst_q, erst_d;
  logic            ewr_q, ewr_d;
  logic [7:0]      eaddr_q, eaddr_d;
  logic [7:0]      edin_q, edin_d;

`ifdef SPI_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  logic          tflag_q, tflag_d;
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT == 0);
`endif

  logic          pick_found;
  logic [IW-1:0] pick_idx;
  logic [IW-1:0] pick_j;
  int            j;

  // Round-robin search starting one past the last served requester.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    pick_j     = '0;
    j          = 0;
    for (int k = 1; k <= NREQ; k++) begin
      j = int'(last_q) + k;
      if (j >= NREQ) j = j - NREQ;
      pick_j = IW'(j);
      if (!pick_found && req[pick_j]) begin
        pick_found = 1'b1;
        pick_idx   = pick_j;
      end
    end
  end

  // Next-state and registered-output computation for the arbiter FSM.
  always_comb begin
    state_d = state_q;
    win_d   = win_q;
    last_d  = last_q;
    gnt_d   = gnt_q;
    vld_d   = '0;
    err_d   = err_q;
    dout_d  = dout_q;
    erst_d  = erst_q;
    ewr_d   = ewr_q;
    eaddr_d = eaddr_q;
    edin_d  = edin_q;
`ifdef SPI_ARB_TIMEOUT_EN
    cnt_d   = cnt_q;
    tflag_d = tflag_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (pick_found) begin
          state_d = CMD;
          win_d   = pick_idx;
          gnt_d   = NREQ'(1) << pick_idx;
          erst_d  = 1'b0;
          ewr_d   = req_wr[pick_idx];
          eaddr_d = 8'(req_addr >> {pick_idx, 3'b000});
          edin_d  = 8'(req_din >> {pick_idx, 3'b000});
        end
      end
      CMD: begin
        state_d = BUSY;
`ifdef SPI_ARB_TIMEOUT_EN
        cnt_d   = '0;
`endif
      end
      BUSY: begin
        if (eng_done) begin
          state_d = RESP;
          vld_d   = NREQ'(1) << win_q;
          err_d   = eng_err;
          dout_d  = ewr_q ? 8'h00 : eng_dout;
`ifdef SPI_ARB_TIMEOUT_EN
        end else if (cnt_q == CW'(TIMEOUT)) begin
          state_d = RESP;
          vld_d   = NREQ'(1) << win_q;
          err_d   = 1'b1;
          dout_d  = 8'h00;
          tflag_d = 1'b1;
        end else begin
          cnt_d   = cnt_q + CW'(1);
`endif
        end
      end
      RESP: begin
        state_d = IDLE;
        last_d  = win_q;
        gnt_d   = '0;
        erst_d  = 1'b1;
        ewr_d   = 1'b0;
        eaddr_d = 8'hFF;
        edin_d  = 8'h00;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      win_q   <= '0;
      last_q  <= IW'(NREQ - 1);
      gnt_q   <= '0;
      vld_q   <= '0;
      err_q   <= 1'b0;
      dout_q  <= 8'h00;
      erst_q  <= 1'b1;
      ewr_q   <= 1'b0;
      eaddr_q <= 8'hFF;
      edin_q  <= 8'h00;
`ifdef SPI_ARB_TIMEOUT_EN
      cnt_q   <= '0;
      tflag_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      win_q   <= win_d;
      last_q  <= last_d;
      gnt_q   <= gnt_d;
      vld_q   <= vld_d;
      err_q   <= err_d;
      dout_q  <= dout_d;
      erst_q  <= erst_d;
      ewr_q   <= ewr_d;
      eaddr_q <= eaddr_d;
      edin_q  <= edin_d;
`ifdef SPI_ARB_TIMEOUT_EN
      cnt_q   <= cnt_d;
      tflag_q <= tflag_d;
`endif
    end
  end

  assign gnt       = gnt_q;
  assign rsp_valid = vld_q;
  assign rsp_err   = err_q;
  assign rsp_dout  = dout_q;
  assign eng_rst   = erst_q;
  assign eng_wr    = ewr_q;
  assign eng_addr  = eaddr_q;
  assign eng_din   = edin_q;
`ifdef SPI_ARB_TIMEOUT_EN
  assign timeout_flag = tflag_q;
`else
  assign timeout_flag = 1'b0;
`endif

endmodule

// File: tb/tb_spi_arb.sv
// tb_spi_arb: directed bench for spi_arb with a behavioural SPI engine model.
// Expected responses are queued at stimulus time and checked as they emerge.
module tb_spi_arb;

  localparam int NREQ = 4;
  localparam int LAT  = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic [3:0]      req;
  logic [3:0]      req_wr;
  logic [31:0]     req_addr;
  logic [31:0]     req_din;
  logic [3:0]      gnt;
  logic [3:0]      rsp_valid;
  logic            rsp_err;
  logic [7:0]      rsp_dout;
  logic            timeout_flag;
  logic            eng_rst;
  logic            eng_wr;
  logic [7:0]      eng_addr;
  logic [7:0]      eng_din;
  logic            eng_done;
  logic            eng_err;
  logic [7:0]      eng_dout;

  spi_arb #(.NREQ(NREQ), .TIMEOUT(20)) dut (
    .clk(clk), .rst(rst),
    .req(req), .req_wr(req_wr), .req_addr(req_addr), .req_din(req_din),
    .gnt(gnt), .rsp_valid(rsp_valid), .rsp_err(rsp_err),
    .rsp_dout(rsp_dout), .timeout_flag(timeout_flag),
    .eng_rst(eng_rst), .eng_wr(eng_wr), .eng_addr(eng_addr),
    .eng_din(eng_din), .eng_done(eng_done), .eng_err(eng_err),
    .eng_dout(eng_dout)
  );

  always #5 clk = ~clk;

  // Engine model: after reset release, completes once after LAT+1 edges.
  logic [7:0] mem [32];
  int         ecnt;
  logic       eng_hang;

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = 8'h00;
  end

  always @(posedge clk) begin
    if (eng_rst) begin
      ecnt     <= 0;
      eng_done <= 1'b0;
      eng_err  <= 1'b0;
      eng_dout <= 8'h00;
    end else begin
      ecnt <= ecnt + 1;
      if (ecnt == LAT && !eng_hang) begin
        eng_done <= 1'b1;
        eng_err  <= (eng_addr >= 8'd32);
        eng_dout <= (eng_addr < 8'd32 && !eng_wr) ? mem[eng_addr[4:0]] : 8'h00;
        if (eng_addr < 8'd32 && eng_wr) mem[eng_addr[4:0]] <= eng_din;
      end else begin
        eng_done <= 1'b0;
      end
    end
  end

  typedef struct packed {
    logic       wr;
    logic [7:0] addr;
    logic [7:0] din;
  } cmd_t;

  typedef struct packed {
    logic [3:0] vld;
    logic       err;
    logic [7:0] dout;
  } exp_t;

  cmd_t cq [NREQ][$];
  exp_t sb [$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic post(input int i, input logic wr, input logic [7:0] a,
                      input logic [7:0] d);
    cmd_t c;
    c.wr = wr; c.addr = a; c.din = d;
    cq[i].push_back(c);
  endtask

  task automatic expect_rsp(input int i, input logic e, input logic [7:0] d);
    exp_t x;
    x.vld = 4'(1 << i); x.err = e; x.dout = d;
    sb.push_back(x);
  endtask

  task automatic drive(input int i);
    cmd_t c;
    c = cq[i].pop_front();
    req_wr[i]          = c.wr;
    req_addr[8*i +: 8] = c.addr;
    req_din[8*i +: 8]  = c.din;
    req[i]             = 1'b1;
  endtask

  task automatic kick();
    for (int i = 0; i < NREQ; i++)
      if (cq[i].size() != 0 && !req[i]) drive(i);
  endtask

  // One cycle: check grant shape, score any response, advance requesters.
  task automatic step();
    exp_t x;
    @(negedge clk);
    if (gnt != 4'b0) chk("gnt_onehot", $countones(gnt), 1);
    if (rsp_valid != 4'b0) begin
      if (sb.size() == 0) begin
        chk("unexpected_rsp", rsp_valid, 0);
      end else begin
        x = sb.pop_front();
        chk("rsp_valid", rsp_valid, x.vld);
        chk("rsp_err", rsp_err, x.err);
        chk("rsp_dout", rsp_dout, x.dout);
      end
      for (int i = 0; i < NREQ; i++)
        if (rsp_valid[i]) begin
          if (cq[i].size() != 0) drive(i);
          else req[i] = 1'b0;
        end
    end
  endtask

  task automatic run_all(input int budget);
    int n;
    n = 0;
    kick();
    while ((sb.size() != 0 || req != 4'b0) && n < budget) begin
      step();
      n++;
    end
    chk("run_done", (sb.size() == 0 && req == 4'b0), 1);
    repeat (2) step();
  endtask

  task automatic pulse_rst();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst      = 1'b1;
    req      = '0;
    req_wr   = '0;
    req_addr = '0;
    req_din  = '0;
    eng_hang = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_gnt", gnt, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_err", rsp_err, 0);
    chk("rst_rsp_dout", rsp_dout, 0);
    chk("rst_tflag", timeout_flag, 0);
    chk("rst_eng_rst", eng_rst, 1);
    chk("rst_eng_addr", eng_addr, 8'hFF);
    chk("rst_eng_wr", eng_wr, 0);
    chk("rst_eng_din", eng_din, 0);
    rst = 1'b0;
    step();

    // Write then read, with grant latency checked on the write.
    post(0, 1'b1, 8'd5, 8'hA5);
    expect_rsp(0, 1'b0, 8'h00);
    kick();
    step();
    chk("cmd_gnt", gnt, 4'b0001);
    chk("cmd_eng_rst", eng_rst, 0);
    chk("cmd_eng_addr", eng_addr, 8'd5);
    chk("cmd_eng_wr", eng_wr, 1);
    chk("cmd_eng_din", eng_din, 8'hA5);
    run_all(40);
    chk("idle_eng_rst", eng_rst, 1);
    chk("idle_eng_addr", eng_addr, 8'hFF);
    post(0, 1'b0, 8'd5, 8'h00);
    expect_rsp(0, 1'b0, 8'hA5);
    run_all(40);

    // All four at once after reset: order 0,1,2,3.
    pulse_rst();
    for (int i = 0; i < NREQ; i++) begin
      post(i, 1'b1, 8'(10 + i), 8'(8'h31 + 8'(i * 17)));
      expect_rsp(i, 1'b0, 8'h00);
    end
    run_all(100);
    for (int i = 0; i < NREQ; i++) begin
      post(i, 1'b0, 8'(10 + i), 8'h00);
      expect_rsp(i, 1'b0, 8'(8'h31 + 8'(i * 17)));
      run_all(40);
    end

    // Fairness: 0 and 2 keep re-requesting; grants alternate.
    post(0, 1'b0, 8'd10, 8'h00);
    post(0, 1'b0, 8'd5, 8'h00);
    post(2, 1'b0, 8'd12, 8'h00);
    post(2, 1'b0, 8'd11, 8'h00);
    expect_rsp(0, 1'b0, 8'h31);
    expect_rsp(2, 1'b0, 8'h53);
    expect_rsp(0, 1'b0, 8'hA5);
    expect_rsp(2, 1'b0, 8'h42);
    run_all(100);

    // Out-of-range read reports error; memory unaffected.
    post(1, 1'b0, 8'd40, 8'h00);
    expect_rsp(1, 1'b1, 8'h00);
    run_all(40);
    post(1, 1'b0, 8'd5, 8'h00);
    expect_rsp(1, 1'b0, 8'hA5);
    run_all(40);

    // Reset during BUSY aborts the write.
    post(3, 1'b1, 8'd5, 8'h77);
    kick();
    for (int n = 0; n < 10 && gnt[3] !== 1'b1; n++) step();
    chk("abort_granted", gnt, 4'b1000);
    step();
    rst    = 1'b1;
    req[3] = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_gnt", gnt, 0);
    chk("abort_eng_rst", eng_rst, 1);
    chk("abort_rsp_valid", rsp_valid, 0);
    repeat (6) step();
    post(1, 1'b0, 8'd5, 8'h00);
    expect_rsp(1, 1'b0, 8'hA5);
    run_all(40);

`ifdef SPI_ARB_TIMEOUT_EN
    eng_hang = 1'b1;
    post(2, 1'b0, 8'd5, 8'h00);
    expect_rsp(2, 1'b1, 8'h00);
    run_all(100);
    chk("tflag_set", timeout_flag, 1);
    eng_hang = 1'b0;
    post(2, 1'b0, 8'd5, 8'h00);
    expect_rsp(2, 1'b0, 8'hA5);
    run_all(40);
    chk("tflag_sticky", timeout_flag, 1);
    pulse_rst();
    chk("tflag_cleared", timeout_flag, 0);
`else
    chk("tflag_tied", timeout_flag, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
